status_serial_rx: RTL

//  Receiver for the alarm status link driven by easySerialOut (state_send/state_out).

---
 rtl/alarm_pkg.sv | 18 +
 rtl/status_serial_rx_link_watchdog.sv | 29 ++
 rtl/status_serial_rx.sv | 113 +++++++++++
 3 files changed

// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm status link: frame width, flag bit positions
// and the receiver state encoding.
package alarm_pkg;

  localparam int MSG_W_DEF = 4;

  localparam int BIT_ARMED = 0;
  localparam int BIT_ALARM = 1;
  localparam int BIT_S1    = 2;
  localparam int BIT_S2    = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } rx_state_t;

endpackage

// File: rtl/status_serial_rx_link_watchdog.sv
// Saturating liveness counter: cleared by each good frame, link is up while the
// count is below LINK_TO.
module link_watchdog #(
  parameter int LINK_TO = 64
) (
  input  logic clk,
  input  logic srst,
  input  logic clr,
  input  logic inc,
  output logic link_ok
);

  localparam int CW = $clog2(LINK_TO + 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      count_reg <= CW'(LINK_TO);
    end else if (clr) begin
      count_reg <= '0;
    end else if (inc && (count_reg < CW'(LINK_TO))) begin
      count_reg <= count_reg + CW'(1);
    end
  end

  assign link_ok = (count_reg < CW'(LINK_TO));

endmodule

// File: rtl/status_serial_rx.sv
// Deserialises status frames from the main module, optionally confirms them on
// two identical consecutive frames, and decodes the armed/alarm/sensor flags.
module status_serial_rx
  import alarm_pkg::*;
#(
  parameter int MSG_W   = MSG_W_DEF,
  parameter int LINK_TO = 64,
  parameter int CONFIRM = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             state_send,
  input  logic             state_out,
  output logic [MSG_W-1:0] msg,
  output logic             msg_valid,
  output logic             armed,
  output logic             alarm,
  output logic             sensor1,
  output logic             sensor2,
  output logic             frame_err,
  output logic             link_ok
);

  localparam int CNT_W = (MSG_W > 1) ? $clog2(MSG_W) : 1;

  rx_state_t        state_reg;
  logic             send_q;
  logic             data_q;
  logic [CNT_W-1:0] bit_cnt_reg;
  logic [MSG_W-1:0] shreg_reg;
  logic [MSG_W-1:0] prev_frame_reg;
  logic             prev_vld_reg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      send_q <= 1'b0;
      data_q <= 1'b0;
    end else begin
      send_q <= state_send;
      data_q <= state_out;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg      <= IDLE;
      bit_cnt_reg    <= '0;
      shreg_reg      <= '0;
      prev_frame_reg <= '0;
      prev_vld_reg   <= 1'b0;
      msg            <= '0;
      msg_valid      <= 1'b0;
      frame_err      <= 1'b0;
    end else begin
      msg_valid <= 1'b0;
      frame_err <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (send_q) begin
            state_reg   <= SHIFT;
            bit_cnt_reg <= '0;
          end
        end
        SHIFT: begin
          // A new start strobe mid-frame restarts reception; the partial frame is dropped.
          if (send_q) begin
            frame_err   <= 1'b1;
            shreg_reg   <= '0;
            bit_cnt_reg <= '0;
          end else begin
            shreg_reg[bit_cnt_reg] <= data_q;
            bit_cnt_reg            <= bit_cnt_reg + CNT_W'(1);
            if (bit_cnt_reg == CNT_W'(MSG_W - 1)) begin
              state_reg <= DONE;
            end
          end
        end
        DONE: begin
          prev_frame_reg <= shreg_reg;
          prev_vld_reg   <= 1'b1;
          if ((CONFIRM == 0) || (prev_vld_reg && (shreg_reg == prev_frame_reg))) begin
            msg       <= shreg_reg;
            msg_valid <= 1'b1;
          end
          // Back-to-back frames with no idle gap are legal.
          if (send_q) begin
            state_reg   <= SHIFT;
            bit_cnt_reg <= '0;
          end else begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign armed   = msg[BIT_ARMED];
  assign alarm   = msg[BIT_ALARM];
  assign sensor1 = msg[BIT_S1];
  assign sensor2 = msg[BIT_S2];

  link_watchdog #(
    .LINK_TO (LINK_TO)
  ) u_watchdog (
    .clk     (CLK),
    .srst    (RST),
    .clr     (state_reg == DONE),
    .inc     (1'b1),
    .link_ok (link_ok)
  );

endmodule
